multicycle_ctrl: RTL

- Moore-style FSM that sequences the team's multicycle RV32I datapath.
- Decodes the latched instruction fields and the ALU `Zero` flag.
- Each cycle, drives the datapath's write enables and mux selects: memory address source, IR/PC/register/memory writes, ALU operand selects, immediate format and ALU operation.
- Sits beside the datapath in the core top level; it is the datapath's only source of control.

---
 rtl/multicycle_ctrl_pkg.sv | 96 +++++++++
 rtl/multicycle_ctrl_alu_decoder.sv | 40 ++++
 rtl/multicycle_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I controller: FSM states, opcodes and datapath select codes.
// The TRAP state exists only when CTRL_ILLEGAL_TRAP_EN is defined.
package ctrl_pkg;

    localparam int STATE_W      = 5;
    localparam int ALU_CTRL_W   = 4;
    localparam int IMM_SRC_W    = 3;
    localparam int RESULT_SRC_W = 2;
    localparam int ALU_SRC_W    = 2;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH,
        S_FETCH_LATCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_JALR,
        S_JALR_JUMP,
        S_LUI,
        S_AUIPC
`ifdef CTRL_ILLEGAL_TRAP_EN
        , S_TRAP
`endif
    } state_t;

    // Selects which rule the ALU decoder applies to funct3/funct7.
    typedef enum logic [1:0] {
        ALUOP_ADD,
        ALUOP_BRANCH,
        ALUOP_FUNC
    } alu_op_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    localparam logic [ALU_CTRL_W-1:0] ALU_ADD  = 4'b0000;
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB  = 4'b0001;
    localparam logic [ALU_CTRL_W-1:0] ALU_AND  = 4'b0010;
    localparam logic [ALU_CTRL_W-1:0] ALU_OR   = 4'b0011;
    localparam logic [ALU_CTRL_W-1:0] ALU_XOR  = 4'b0100;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT  = 4'b0101;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLTU = 4'b0110;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLL  = 4'b0111;
    localparam logic [ALU_CTRL_W-1:0] ALU_SRL  = 4'b1000;
    localparam logic [ALU_CTRL_W-1:0] ALU_SRA  = 4'b1001;

    localparam logic [IMM_SRC_W-1:0] IMM_I = 3'b000;
    localparam logic [IMM_SRC_W-1:0] IMM_S = 3'b001;
    localparam logic [IMM_SRC_W-1:0] IMM_B = 3'b010;
    localparam logic [IMM_SRC_W-1:0] IMM_J = 3'b011;
    localparam logic [IMM_SRC_W-1:0] IMM_U = 3'b100;

    localparam logic [RESULT_SRC_W-1:0] RES_ALUOUT  = 2'b00;
    localparam logic [RESULT_SRC_W-1:0] RES_MEMDATA = 2'b01;
    localparam logic [RESULT_SRC_W-1:0] RES_ALURES  = 2'b10;

    localparam logic [ALU_SRC_W-1:0] SRCA_PC    = 2'b00;
    localparam logic [ALU_SRC_W-1:0] SRCA_OLDPC = 2'b01;
    localparam logic [ALU_SRC_W-1:0] SRCA_RS1   = 2'b10;
    localparam logic [ALU_SRC_W-1:0] SRCA_ZERO  = 2'b11;

    localparam logic [ALU_SRC_W-1:0] SRCB_RS2  = 2'b00;
    localparam logic [ALU_SRC_W-1:0] SRCB_IMM  = 2'b01;
    localparam logic [ALU_SRC_W-1:0] SRCB_FOUR = 2'b10;

    // Branch outcome from the ALU Zero flag: SUB compares equality, SLT/SLTU give 1 (non-zero) when less.
    function automatic logic branch_taken(input logic [2:0] f3, input logic zero);
        logic taken;
        case (f3)
            3'b000:  taken = zero;
            3'b001:  taken = !zero;
            3'b100:  taken = !zero;
            3'b101:  taken = zero;
            3'b110:  taken = !zero;
            3'b111:  taken = zero;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// Combinational ALU operation decoder: maps the FSM's ALU op class plus funct3/funct7[5] to alu_control.
// I-type instructions only honour funct7[5] for shifts, so ADDI never becomes SUB.
module alu_decoder
    import ctrl_pkg::*;
(
    input  alu_op_t                 alu_op,
    input  logic [2:0]              funct3,
    input  logic                    funct7_5,
    input  logic                    is_rtype,
    output logic [ALU_CTRL_W-1:0]   alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_BRANCH: begin
                case (funct3)
                    3'b100, 3'b101: alu_control = ALU_SLT;
                    3'b110, 3'b111: alu_control = ALU_SLTU;
                    default:        alu_control = ALU_SUB;
                endcase
            end
            ALUOP_FUNC: begin
                case (funct3)
                    3'b000:  alu_control = (is_rtype && funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_control = ALU_SLL;
                    3'b010:  alu_control = ALU_SLT;
                    3'b011:  alu_control = ALU_SLTU;
                    3'b100:  alu_control = ALU_XOR;
                    3'b101:  alu_control = funct7_5 ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_control = ALU_OR;
                    default: alu_control = ALU_AND;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore FSM that sequences the multicycle RV32I datapath; outputs decode from the current state.
// Build option CTRL_ILLEGAL_TRAP_EN: unknown opcodes park in TRAP with illegal=1 until reset.
module multicycle_ctrl
    import ctrl_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic [6:0]              op_code,
    input  logic [2:0]              funct3,
    input  logic [6:0]              funct7,
    input  logic                    Zero,
    output logic                    adr_src,
    output logic                    mem_write,
    output logic                    IR_write,
    output logic                    reg_write,
    output logic                    PC_write,
    output logic [RESULT_SRC_W-1:0] result_src,
    output logic [ALU_SRC_W-1:0]    alu_src_a,
    output logic [ALU_SRC_W-1:0]    alu_src_b,
    output logic [IMM_SRC_W-1:0]    imm_src,
    output logic [ALU_CTRL_W-1:0]   alu_control,
    output logic                    illegal
);

    state_t  state_reg;
    alu_op_t alu_op;
    logic    is_rtype;
    logic    adr_src_raw;
    logic    mem_write_raw;
    logic    ir_write_raw;
    logic    reg_write_raw;
    logic    pc_write_raw;
    logic    unused_funct7;

    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_FETCH;
        end else begin
            case (state_reg)
                S_FETCH:       state_reg <= S_FETCH_LATCH;
                S_FETCH_LATCH: state_reg <= S_DECODE;
                S_DECODE: begin
                    case (op_code)
                        OP_LOAD, OP_STORE: state_reg <= S_MEMADR;
                        OP_RTYPE:          state_reg <= S_EXECUTER;
                        OP_ITYPE:          state_reg <= S_EXECUTEI;
                        OP_BRANCH:         state_reg <= S_BRANCH;
                        OP_JAL:            state_reg <= S_JAL;
                        OP_JALR:           state_reg <= S_JALR;
                        OP_LUI:            state_reg <= S_LUI;
                        OP_AUIPC:          state_reg <= S_AUIPC;
                        OP_FENCE:          state_reg <= S_FETCH;
`ifdef CTRL_ILLEGAL_TRAP_EN
                        default:           state_reg <= S_TRAP;
`else
                        default:           state_reg <= S_FETCH;
`endif
                    endcase
                end
                S_MEMADR:    state_reg <= (op_code == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
                S_MEMREAD:   state_reg <= S_MEMWB;
                S_MEMWB:     state_reg <= S_FETCH;
                S_MEMWRITE:  state_reg <= S_FETCH;
                S_EXECUTER:  state_reg <= S_ALUWB;
                S_EXECUTEI:  state_reg <= S_ALUWB;
                S_ALUWB:     state_reg <= S_FETCH;
                S_BRANCH:    state_reg <= S_FETCH;
                S_JAL:       state_reg <= S_ALUWB;
                S_JALR:      state_reg <= S_JALR_JUMP;
                S_JALR_JUMP: state_reg <= S_ALUWB;
                S_LUI:       state_reg <= S_ALUWB;
                S_AUIPC:     state_reg <= S_ALUWB;
`ifdef CTRL_ILLEGAL_TRAP_EN
                S_TRAP:      state_reg <= S_TRAP;
`endif
                default:     state_reg <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        adr_src_raw   = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        pc_write_raw  = 1'b0;
        result_src    = RES_ALUOUT;
        alu_src_a     = SRCA_PC;
        alu_src_b     = SRCB_RS2;
        imm_src       = IMM_I;
        alu_op        = ALUOP_ADD;
        is_rtype      = 1'b0;
        case (state_reg)
            S_FETCH: adr_src_raw = 1'b0;
            S_FETCH_LATCH: begin
                ir_write_raw = 1'b1;
                pc_write_raw = 1'b1;
                alu_src_b    = SRCB_FOUR;
                result_src   = RES_ALURES;
            end
            // Speculative branch/jump target into ALUOut while the opcode is decoded.
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                imm_src   = (op_code == OP_JAL) ? IMM_J : IMM_B;
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                imm_src   = (op_code == OP_STORE) ? IMM_S : IMM_I;
            end
            S_MEMREAD: adr_src_raw = 1'b1;
            S_MEMWB: begin
                adr_src_raw   = 1'b1;
                result_src    = RES_MEMDATA;
                reg_write_raw = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src_raw   = 1'b1;
                mem_write_raw = 1'b1;
            end
            S_EXECUTER: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_RS2;
                alu_op    = ALUOP_FUNC;
                is_rtype  = 1'b1;
            end
            S_EXECUTEI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_FUNC;
            end
            S_ALUWB: reg_write_raw = 1'b1;
            S_BRANCH: begin
                alu_src_a    = SRCA_RS1;
                alu_src_b    = SRCB_RS2;
                alu_op       = ALUOP_BRANCH;
                pc_write_raw = branch_taken(funct3, Zero);
            end
            // PC takes the target already in ALUOut; ALUOut becomes the link value oldPC+4.
            S_JAL, S_JALR_JUMP: begin
                alu_src_a    = SRCA_OLDPC;
                alu_src_b    = SRCB_FOUR;
                pc_write_raw = 1'b1;
            end
            S_JALR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
            end
            S_LUI: begin
                alu_src_a = SRCA_ZERO;
                alu_src_b = SRCB_IMM;
                imm_src   = IMM_U;
            end
            S_AUIPC: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                imm_src   = IMM_U;
            end
            default: adr_src_raw = 1'b0;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .funct7_5    (funct7[5]),
        .is_rtype    (is_rtype),
        .alu_control (alu_control)
    );

    // Reset masks every enable immediately so an aborted instruction cannot write anything.
    assign adr_src   = adr_src_raw   & ~reset;
    assign mem_write = mem_write_raw & ~reset;
    assign IR_write  = ir_write_raw  & ~reset;
    assign reg_write = reg_write_raw & ~reset;
    assign PC_write  = pc_write_raw  & ~reset;

`ifdef CTRL_ILLEGAL_TRAP_EN
    assign illegal = (state_reg == S_TRAP) & ~reset;
`else
    assign illegal = 1'b0;
`endif

endmodule
